pll_reconfig_ctrl: RTL and testbench
====================================

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles pll_reset is held high per sequence (legal range 2..255).
REQ-002 SHALL have parameter LOCK_STABLE, default 255: consecutive synchronized-lock-high cycles required before ready (legal range 1..255).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum WAIT_LOCK+STABLE cycles before failure (legal range 1..65535).
REQ-004 SHALL have parameters PROFILE0..PROFILE3, 18 bits each, defaults 18'h3F03C, 18'h3E03C, 18'h3F07E, 18'h3D038: packed {idsel[5:0], fbdsel[5:0], odsel[5:0]} raw PLL dynamic-port encodings.
REQ-005 Ports, as name  direction  width  meaning:
clkin  input  1  reference clock; free-running, never the PLL output.
rst_n  input  1  synchronous active-low reset.
req  input  1  reconfiguration request, level-sampled.
sel_idx  input  2  profile index, sampled with req.
pll_lock  input  1  PLL LOCK, asynchronous to clkin.
pll_reset  output  1  PLL RESET, active high.
idsel  output  6  PLL IDSEL.
fbdsel  output  6  PLL FBDSEL.
odsel  output  6  PLL ODSEL.
cur_idx  output  2  profile currently applied.
busy  output  1  sequence in progress.
ready  output  1  PLL locked and stable.
done  output  1  one-cycle pulse on entry to READY.
fail  output  1  lock timeout; held until the next accepted request.
lock_lost  output  1  sticky: lock dropped while READY; cleared by an accepted request.

Function
REQ-006 SHALL pass pll_lock through a 2-flop synchronizer; all lock decisions SHALL use the synchronized value (lock_s), adding 2 cycles of latency.
REQ-007 SHALL implement states ASSERT, WAIT_LOCK, STABLE, READY, FAIL.
REQ-008 ASSERT: pll_reset=1; busy=1; SHALL stay exactly RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-009 WAIT_LOCK: pll_reset=0; busy=1; when lock_s=1, go to STABLE; timeout counter increments every WAIT_LOCK and STABLE cycle.
REQ-010 STABLE: stable counter increments while lock_s=1; after LOCK_STABLE consecutive high cycles, go to READY; lock_s=0 clears the stable counter and returns to WAIT_LOCK without clearing the timeout counter.
REQ-011 The timeout counter SHALL be cleared on entry to ASSERT; when it reaches LOCK_TIMEOUT in WAIT_LOCK or STABLE, the block SHALL go to FAIL, with the timeout check taking priority over a same-cycle transition to READY.
REQ-012 READY: busy=0; ready=1; pll_reset=0; done=1 on the entry cycle only.
REQ-013 READY: lock_s=0 SHALL set lock_lost=1, clear ready, and re-enter ASSERT with the unchanged profile (auto-retry), unless a request is accepted in the same cycle (REQ-015).
REQ-014 FAIL: pll_reset=1; fail=1; busy=0; ready=0; the block SHALL stay in FAIL until a request is accepted.
REQ-015 Requests SHALL be accepted only in READY or FAIL when req=1. On acceptance the block SHALL:
- latch sel_idx into cur_idx;
- load idsel/fbdsel/odsel from PROFILE[sel_idx] on the next edge, the same edge pll_reset rises;
- clear fail and lock_lost;
- enter ASSERT.
Acceptance SHALL take priority over lock loss in the same cycle.
REQ-016 req in ASSERT, WAIT_LOCK or STABLE SHALL be ignored, not queued.
REQ-017 idsel/fbdsel/odsel SHALL change only on entry to ASSERT and SHALL stay constant while pll_reset=0.
REQ-018 Counters SHALL saturate and never wrap; widths: 8 bits for RST_CYCLES and LOCK_STABLE, 16 bits for LOCK_TIMEOUT.

Reset
REQ-019 On rst_n=0 at a clkin edge, from any state, the block SHALL enter ASSERT with:
- cur_idx=0; idsel/fbdsel/odsel = PROFILE0 fields;
- pll_reset=1; busy=1;
- ready=0, done=0, fail=0, lock_lost=0;
- synchronizer and all counters cleared.
REQ-020 After rst_n returns high, power-on sequencing SHALL proceed per REQ-008..REQ-012 with no request required.

Verification (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=100)
REQ-021 Power-on: rst_n low 3 cycles then high; pll_lock=1 from cycle 10 -> pll_reset high exactly 4 cycles after release; ready=1 and a 1-cycle done pulse 2+8 cycles after lock_s would first sample high; outputs = PROFILE0.
REQ-022 Reconfigure: in READY, req=1 with sel_idx=2 for one cycle; pll_lock drops 2 cycles later and returns 20 cycles later -> next edge cur_idx=2 and odsel=PROFILE2[5:0]; pll_reset high 4 cycles; ready again with done pulse.
REQ-023 Lock glitch in STABLE: lock low for 1 cycle after 5 stable cycles -> stable count restarts; ready only after 8 fresh consecutive high cycles; timeout counter continues.
REQ-024 Timeout: pll_lock held 0 -> fail=1 and pll_reset=1 exactly 100 cycles after WAIT_LOCK entry; then req=1, sel_idx=1 -> fail clears and ASSERT restarts with PROFILE1.
REQ-025 Lock loss in READY: pll_lock drops -> lock_lost=1, ready=0, ASSERT re-entered with the same cur_idx; in the same-cycle case, req=1 in that cycle wins and lock_lost=0.
REQ-026 Mid-sequence reset: rst_n low during WAIT_LOCK with cur_idx=3 -> next edge all outputs at REQ-019 values; req during ASSERT ignored.

Source files
------------

// File: rtl/pll_reconfig_ctrl.sv
// PLL dynamic reconfiguration controller: applies one of four divider profiles,
// sequences PLL reset, qualifies lock and reports ready / timeout / lock loss.
module pll_reconfig_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 255,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter logic [17:0] PROFILE0     = 18'h3F03C,
  parameter logic [17:0] PROFILE1     = 18'h3E03C,
  parameter logic [17:0] PROFILE2     = 18'h3F07E,
  parameter logic [17:0] PROFILE3     = 18'h3D038
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       req,
  input  logic [1:0] sel_idx,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic [1:0] cur_idx,
  output logic       busy,
  output logic       ready,
  output logic       done,
  output logic       fail,
  output logic       lock_lost
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TO_W  = 16;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_MAX  = CNT_W'(LOCK_STABLE);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(LOCK_TIMEOUT);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_READY,
    ST_FAIL
  } state_t;

  state_t           state;
  logic             lock_meta;
  logic             lock_s;
  logic [CNT_W-1:0] rst_cnt;
  logic [CNT_W-1:0] stb_cnt;
  logic [TO_W-1:0]  to_cnt;

  logic [CNT_W-1:0] rst_inc;
  logic [CNT_W-1:0] stb_inc;
  logic [TO_W-1:0]  to_inc;
  logic [17:0]      profile_sel;
  logic             accept;
  logic             restart;

  function automatic logic [17:0] profile_of(input logic [1:0] idx);
    case (idx)
      2'd0:    profile_of = PROFILE0;
      2'd1:    profile_of = PROFILE1;
      2'd2:    profile_of = PROFILE2;
      default: profile_of = PROFILE3;
    endcase
  endfunction

  // Saturating increments so no counter can wrap
  assign rst_inc = (rst_cnt == '1) ? rst_cnt : rst_cnt + CNT_W'(1);
  assign stb_inc = (stb_cnt == '1) ? stb_cnt : stb_cnt + CNT_W'(1);
  assign to_inc  = (to_cnt  == '1) ? to_cnt  : to_cnt  + TO_W'(1);

  assign profile_sel = profile_of(sel_idx);
  assign accept      = req && (state == ST_READY || state == ST_FAIL);
  // A request outranks lock loss; lock loss alone retries the current profile
  assign restart     = accept || (state == ST_READY && !lock_s);

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state     <= ST_ASSERT;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      rst_cnt   <= '0;
      stb_cnt   <= '0;
      to_cnt    <= '0;
      cur_idx   <= 2'd0;
      idsel     <= PROFILE0[17:12];
      fbdsel    <= PROFILE0[11:6];
      odsel     <= PROFILE0[5:0];
      pll_reset <= 1'b1;
      busy      <= 1'b1;
      ready     <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      done      <= 1'b0;
      case (state)
        ST_ASSERT: begin
          if (rst_cnt >= RST_LAST) begin
            state     <= ST_WAIT_LOCK;
            rst_cnt   <= '0;
            pll_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_inc;
          end
        end
        ST_WAIT_LOCK, ST_STABLE: begin
          to_cnt <= to_inc;
          if (to_inc >= TO_MAX) begin
            state     <= ST_FAIL;
            stb_cnt   <= '0;
            pll_reset <= 1'b1;
            busy      <= 1'b0;
            fail      <= 1'b1;
          end else if (!lock_s) begin
            state   <= ST_WAIT_LOCK;
            stb_cnt <= '0;
          end else if (state == ST_WAIT_LOCK) begin
            state   <= ST_STABLE;
            stb_cnt <= '0;
          end else if (stb_inc >= STB_MAX) begin
            state   <= ST_READY;
            stb_cnt <= '0;
            busy    <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b1;
          end else begin
            stb_cnt <= stb_inc;
          end
        end
        ST_READY, ST_FAIL: begin
          if (restart) begin
            state     <= ST_ASSERT;
            rst_cnt   <= '0;
            stb_cnt   <= '0;
            to_cnt    <= '0;
            pll_reset <= 1'b1;
            busy      <= 1'b1;
            ready     <= 1'b0;
            if (accept) begin
              cur_idx   <= sel_idx;
              idsel     <= profile_sel[17:12];
              fbdsel    <= profile_sel[11:6];
              odsel     <= profile_sel[5:0];
              fail      <= 1'b0;
              lock_lost <= 1'b0;
            end else begin
              lock_lost <= 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_ASSERT;
          rst_cnt   <= '0;
          pll_reset <= 1'b1;
          busy      <= 1'b1;
          ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Randomized scenario bench for pll_reconfig_ctrl against a phase/age-based
// reference model, comparing all outputs every cycle.
module tb_pll_reconfig_ctrl;

  localparam int unsigned RST = 4;
  localparam int unsigned STB = 8;
  localparam int unsigned TO  = 100;
  localparam logic [17:0] PROF [4] = '{18'h3F03C, 18'h3E03C, 18'h3F07E, 18'h3D038};

  logic       clkin = 1'b0;
  logic       rst_n;
  logic       req;
  logic [1:0] sel_idx;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] idsel, fbdsel, odsel;
  logic [1:0] cur_idx;
  logic       busy, ready, done, fail, lock_lost;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: sequence age, time spent hunting lock, stable run length
  bit         m_active, m_ready, m_done, m_fail, m_lost, m_counting;
  int         m_age, m_wait, m_run;
  logic [1:0] m_idx;
  bit         s1, s2;

  pll_reconfig_ctrl #(
    .RST_CYCLES  (RST),
    .LOCK_STABLE (STB),
    .LOCK_TIMEOUT(TO)
  ) dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .req      (req),
    .sel_idx  (sel_idx),
    .pll_lock (pll_lock),
    .pll_reset(pll_reset),
    .idsel    (idsel),
    .fbdsel   (fbdsel),
    .odsel    (odsel),
    .cur_idx  (cur_idx),
    .busy     (busy),
    .ready    (ready),
    .done     (done),
    .fail     (fail),
    .lock_lost(lock_lost)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic start_seq(input logic [1:0] idx);
    m_active   = 1'b1;
    m_ready    = 1'b0;
    m_age      = 0;
    m_wait     = 0;
    m_run      = 0;
    m_counting = 1'b0;
    m_idx      = idx;
  endtask

  task automatic model_step();
    bit ls;
    ls = s2;
    if (!rst_n) begin
      start_seq(2'd0);
      m_done = 1'b0;
      m_fail = 1'b0;
      m_lost = 1'b0;
      s1 = 1'b0;
      s2 = 1'b0;
      return;
    end
    s2 = s1;
    s1 = pll_lock;
    m_done = 1'b0;
    if (!m_active) begin
      if (req) begin
        start_seq(sel_idx);
        m_fail = 1'b0;
        m_lost = 1'b0;
      end else if (m_ready && !ls) begin
        m_lost = 1'b1;
        start_seq(m_idx);
      end
    end else if (m_age < int'(RST)) begin
      m_age++;
    end else begin
      m_wait++;
      if (m_wait >= int'(TO)) begin
        m_active = 1'b0;
        m_fail   = 1'b1;
      end else if (m_counting) begin
        if (ls) begin
          m_run++;
          if (m_run >= int'(STB)) begin
            m_active = 1'b0;
            m_ready  = 1'b1;
            m_done   = 1'b1;
          end
        end else begin
          m_counting = 1'b0;
          m_run      = 0;
        end
      end else if (ls) begin
        m_counting = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs();
    bit exp_rst;
    exp_rst = m_fail || (m_active && m_age < int'(RST));
    check("ctrl", 32'({pll_reset, busy, ready, done, fail, lock_lost}),
          32'({exp_rst, m_active, m_ready, m_done, m_fail, m_lost}));
    check("cfg", 32'({cur_idx, idsel, fbdsel, odsel}), 32'({m_idx, PROF[m_idx]}));
  endtask

  task automatic tick();
    @(posedge clkin);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_req(input logic [1:0] idx);
    req = 1'b1;
    sel_idx = idx;
    tick();
    req = 1'b0;
  endtask

  // Bounded wait for READY with lock held; a stuck FAIL is kicked by a request
  task automatic wait_ready();
    pll_lock = 1'b1;
    for (int i = 0; i < 400 && !ready; i++) begin
      if (m_fail) pulse_req(2'($urandom_range(0, 3)));
      else tick();
    end
    check("wait_ready", 32'(ready), 32'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0;
    sel_idx = 2'd0;
    pll_lock = 1'b0;
    // Power-on: reset three cycles, lock appears at cycle 10
    run(3);
    rst_n = 1'b1;
    run(7);
    pll_lock = 1'b1;
    run(30);
    check("poweron_ready", 32'(ready), 32'(1));

    for (int seg = 0; seg < 30; seg++) begin
      case ($urandom_range(0, 5))
        0: begin  // reconfigure with lock dropping during the reset pulse
          wait_ready();
          pulse_req(2'($urandom_range(0, 3)));
          tick();
          pll_lock = 1'b0;
          run(20);
          pll_lock = 1'b1;
          run(5);
        end
        1: begin  // single-cycle lock glitch somewhere in the lock hunt
          wait_ready();
          pulse_req(2'($urandom_range(0, 3)));
          run($urandom_range(0, 15));
          pll_lock = 1'b0;
          tick();
          pll_lock = 1'b1;
          run(40);
        end
        2: begin  // timeout then recovery on profile 1
          wait_ready();
          pulse_req(2'($urandom_range(0, 3)));
          pll_lock = 1'b0;
          run(120);
          check("timeout_fail", 32'(fail), 32'(1));
          pulse_req(2'd1);
          pll_lock = 1'b1;
          run(20);
        end
        3: begin  // lock loss in READY, optionally racing a request
          wait_ready();
          pll_lock = 1'b0;
          run(2);
          req = 1'($urandom_range(0, 1));
          sel_idx = 2'($urandom_range(0, 3));
          tick();
          req = 1'b0;
          pll_lock = 1'b1;
          run(10);
        end
        4: begin  // reset mid-sequence on profile 3, request during ASSERT ignored
          wait_ready();
          pulse_req(2'd3);
          pll_lock = 1'b0;
          run(7);
          rst_n = 1'b0;
          run(2);
          rst_n = 1'b1;
          pulse_req(2'($urandom_range(0, 3)));
          pll_lock = 1'b1;
          run(20);
        end
        default: begin  // noisy lock with sporadic requests
          for (int i = 0; i < 80; i++) begin
            pll_lock = ($urandom_range(0, 19) != 0);
            req = ($urandom_range(0, 9) == 0);
            sel_idx = 2'($urandom_range(0, 3));
            tick();
          end
          req = 1'b0;
          pll_lock = 1'b1;
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
